pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage RISC-V pipeline.
//  - Detects load-use hazards, branch-taken redirects from MEM and data-memory wait states.
//  - Drives the per-stage stall/flush controls of the IF/ID, ID/EX and EX/MEM registers and the PC.
//  - Sits beside the forwarding unit and covers the hazards forwarding cannot resolve.
//  - Keeps saturating stall/flush performance counters and a wait-timeout error flag.
// PARAMETERS
//  REG_AW    5   register-address width
//  CNT_W     32  performance-counter width
//  MAX_WAIT  16  consecutive dmem_busy_i cycles before timeout_o sets (>=1)
// PORTS
//  clk_i             in   1      clock, all state on rising edge
//  reset_i           in   1      asynchronous, active-low reset
//  id_rs1_i          in   REG_AW rs1 of instruction in DECODE
//  id_rs2_i          in   REG_AW rs2 of instruction in DECODE
//  ex_memread_i      in   1      instruction in EXECUTE is a load
//  ex_rd_i           in   REG_AW destination of instruction in EXECUTE
//  mem_branch_taken_i in  1      PCSrc: branch resolved taken in MEMORY_ACCESS
//  dmem_busy_i       in   1      data memory cannot complete access this cycle
//  pc_stall_o        out  1      hold PC
//  ifid_stall_o      out  1      hold IF/ID register
//  idex_stall_o      out  1      hold ID/EX register
//  exmem_stall_o     out  1      hold EX/MEM register and MEM/WB (freeze)
//  ifid_flush_o      out  1      load NOP into IF/ID
//  idex_flush_o      out  1      load bubble (all controls 0) into ID/EX
//  exmem_flush_o     out  1      load bubble into EX/MEM
//  stall_cnt_o       out  CNT_W  cycles with pc_stall_o=1, saturating
//  flush_cnt_o       out  CNT_W  branch redirects taken, saturating
//  timeout_o         out  1      sticky: dmem_busy_i held > MAX_WAIT cycles
// BEHAVIOUR
//  - Reset (reset_i=0, async): state=RUN, counters=0, wait_cnt=0, timeout_o=0.
//    All stall/flush outputs are 0 while in reset.
//  - Outputs are combinational from the registered state and the current inputs (Mealy).
//    They take effect at the same clock edge.
//  - Priority: dmem_busy_i > mem_branch_taken_i > load-use.
//  - Load-use condition: ex_memread_i & ex_rd_i!=0 & (ex_rd_i==id_rs1_i | ex_rd_i==id_rs2_i).
//  - FSM states: RUN, LU_STALL, FREEZE.
//  - RUN:
//    - dmem_busy_i=1 -> all four stalls=1, no flush; next FREEZE.
//    - else branch=1 -> ifid/idex/exmem_flush=1, no stall; next RUN.
//      Flush wins over a coincident load-use; the load-use is not recorded.
//    - else load-use=1 -> pc_stall, ifid_stall=1, idex_flush=1; next LU_STALL.
//    - else all outputs 0.
//  - LU_STALL (exactly 1 cycle):
//    - The bubble now occupies EX and load-use detection is masked.
//    - dmem_busy_i -> FREEZE; branch -> flush as in RUN; otherwise outputs 0. Next RUN.
//  - FREEZE:
//    - While dmem_busy_i=1: all stalls=1 and flushes=0.
//      A branch held in the frozen EX/MEM is acted on the first cycle after busy drops.
//    - dmem_busy_i=0 -> evaluate as RUN in the same cycle; next per RUN rules.
//  - Wait counter:
//    - wait_cnt increments each cycle dmem_busy_i=1 and clears when it is 0.
//    - When wait_cnt==MAX_WAIT while still busy, timeout_o sets. Only reset clears it.
//  - Counters saturate at all-ones; no wrap.
//    stall_cnt_o increments on every cycle pc_stall_o=1.
//    flush_cnt_o increments on every cycle ifid_flush_o=1.
//  - Reset mid-stall or mid-freeze aborts immediately to RUN.
//    The pipeline registers are reset by their own stages.
// STRUCTURE
//  - Package riscv_pipe_pkg holds:
//    - hz_state_t enum {RUN, LU_STALL, FREEZE}
//    - hz_ctrl_t packed struct of the 7 stall/flush bits
//    - the NOP instruction constant 32'h0000_0013
//  - One sub-module, sat_counter #(W), instantiated twice for the performance counters.
//  - The FSM and hazard compare stay in this module.
// TESTING
//  1. Hazard with rd=x0 masked: lw x5 in EX (ex_rd_i=5, ex_memread_i=1), id_rs1_i=5
//     -> pc_stall_o=ifid_stall_o=idex_flush_o=1 for exactly 1 cycle, stall_cnt_o=1.
//     Then ex_rd_i=0 with id_rs1_i=0 -> no stall.
//  2. mem_branch_taken_i=1 together with a load-use match
//     -> ifid/idex/exmem_flush=1, no stalls, flush_cnt_o increments by 1, state stays RUN.
//  3. dmem_busy_i=1 for 3 cycles with mem_branch_taken_i=1 held
//     -> 3 cycles all stalls=1 and flushes=0, then 1 cycle of flushes, stall_cnt_o=3.
//  4. dmem_busy_i=1 for MAX_WAIT+1=17 cycles -> timeout_o rises on cycle 17 and stays 1
//     after busy drops, until reset_i=0.
//  5. Drive reset_i=0 asynchronously mid-LU_STALL and mid-FREEZE
//     -> all outputs 0 with no clock edge, counters 0, resumes in RUN after release.
//  6. Preload counters to all-ones with CNT_W=4 and run 20 load-use stalls
//     -> stall_cnt_o holds 4'hF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: sequencer states, the
// stall/flush control bundle and the canonical NOP instruction.
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FREEZE   = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic pcStall;
    logic ifidStall;
    logic idexStall;
    logic exmemStall;
    logic ifidFlush;
    logic idexFlush;
    logic exmemFlush;
  } hz_ctrl_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Canned control patterns, bit order matches hz_ctrl_t (pcStall first)
  localparam hz_ctrl_t CTRL_IDLE     = 7'b000_0000;
  localparam hz_ctrl_t CTRL_FREEZE   = 7'b111_1000;
  localparam hz_ctrl_t CTRL_REDIRECT = 7'b000_0111;
  localparam hz_ctrl_t CTRL_LOAD_USE = 7'b110_0010;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: decode/execute operand info and memory status in,
// per-stage stall/flush controls and performance counters out.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic              ex_memread_i;
  logic [REG_AW-1:0] ex_rd_i;
  logic              mem_branch_taken_i;
  logic              dmem_busy_i;
  logic              pc_stall_o;
  logic              ifid_stall_o;
  logic              idex_stall_o;
  logic              exmem_stall_o;
  logic              ifid_flush_o;
  logic              idex_flush_o;
  logic              exmem_flush_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;
  logic              timeout_o;

  modport master (
    output id_rs1_i, id_rs2_i, ex_memread_i, ex_rd_i, mem_branch_taken_i, dmem_busy_i,
    input  pc_stall_o, ifid_stall_o, idex_stall_o, exmem_stall_o,
           ifid_flush_o, idex_flush_o, exmem_flush_o,
           stall_cnt_o, flush_cnt_o, timeout_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, ex_memread_i, ex_rd_i, mem_branch_taken_i, dmem_busy_i,
    output pc_stall_o, ifid_stall_o, idex_stall_o, exmem_stall_o,
           ifid_flush_o, idex_flush_o, exmem_flush_o,
           stall_cnt_o, flush_cnt_o, timeout_o
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters;
// it sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, taken
// branch redirect from MEM, and data-memory freeze with a wait-timeout flag.
module pipeline_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 16
) (
  input logic                   clk_i,
  input logic                   reset_i,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [REG_AW-1:0] REG_X0     = '0;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  hz_state_t         state;
  hz_state_t         stateNext;
  hz_ctrl_t          ctrlRaw;
  hz_ctrl_t          ctrl;
  logic              loadUse;
  logic              luMasked;
  logic [WAIT_W-1:0] waitCnt;
  logic              timeout;

  assign loadUse = hz.ex_memread_i && (hz.ex_rd_i != REG_X0) &&
                   ((hz.ex_rd_i == hz.id_rs1_i) || (hz.ex_rd_i == hz.id_rs2_i));

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= RUN;
    end else begin
      state <= stateNext;
    end
  end

  // FREEZE with busy low falls through to the RUN rules; LU_STALL only masks
  // load-use because the bubble it inserted is now sitting in EX.
  always_comb begin
    ctrlRaw   = CTRL_IDLE;
    stateNext = RUN;
    luMasked  = (state == LU_STALL);
    if (hz.dmem_busy_i) begin
      ctrlRaw   = CTRL_FREEZE;
      stateNext = FREEZE;
    end else if (hz.mem_branch_taken_i) begin
      ctrlRaw   = CTRL_REDIRECT;
    end else if (loadUse && !luMasked) begin
      ctrlRaw   = CTRL_LOAD_USE;
      stateNext = LU_STALL;
    end
  end

  assign ctrl = reset_i ? ctrlRaw : CTRL_IDLE;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      waitCnt <= '0;
      timeout <= 1'b0;
    end else if (hz.dmem_busy_i) begin
      if (waitCnt != WAIT_LIMIT) begin
        waitCnt <= waitCnt + 1'b1;
      end else begin
        timeout <= 1'b1;
      end
    end else begin
      waitCnt <= '0;
    end
  end

  sat_counter #(.W(CNT_W)) stallCounter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc     (ctrl.pcStall),
    .count   (hz.stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) flushCounter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc     (ctrl.ifidFlush),
    .count   (hz.flush_cnt_o)
  );

  assign hz.pc_stall_o    = ctrl.pcStall;
  assign hz.ifid_stall_o  = ctrl.ifidStall;
  assign hz.idex_stall_o  = ctrl.idexStall;
  assign hz.exmem_stall_o = ctrl.exmemStall;
  assign hz.ifid_flush_o  = ctrl.ifidFlush;
  assign hz.idex_flush_o  = ctrl.idexFlush;
  assign hz.exmem_flush_o = ctrl.exmemFlush;
  assign hz.timeout_o     = timeout;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios plus
// random traffic against a cycle-level behavioural model; a 4-bit twin checks saturation.
module tb_pipeline_hazard_ctrl;

  localparam int MAX_WAIT = 16;
  localparam logic [6:0] EXP_IDLE   = 7'b000_0000;
  localparam logic [6:0] EXP_FREEZE = 7'b111_1000;
  localparam logic [6:0] EXP_FLUSH  = 7'b000_0111;
  localparam logic [6:0] EXP_LU     = 7'b110_0010;

  logic       clk;
  logic       rstN;
  logic [4:0] idRs1;
  logic [4:0] idRs2;
  logic       exMemread;
  logic [4:0] exRd;
  logic       branch;
  logic       busy;

  int checks = 0;
  int passes = 0;

  // Reference model state: bubble presence in EX, busy run length, counts
  bit          mBubbleInEx;
  int          mBusyRun;
  bit          mTimeout;
  int unsigned mStall;
  int unsigned mFlush;

  pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) hzIf ();
  pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  hzSmall ();

  assign hzIf.id_rs1_i              = idRs1;
  assign hzIf.id_rs2_i              = idRs2;
  assign hzIf.ex_memread_i          = exMemread;
  assign hzIf.ex_rd_i               = exRd;
  assign hzIf.mem_branch_taken_i    = branch;
  assign hzIf.dmem_busy_i           = busy;
  assign hzSmall.id_rs1_i           = idRs1;
  assign hzSmall.id_rs2_i           = idRs2;
  assign hzSmall.ex_memread_i       = exMemread;
  assign hzSmall.ex_rd_i            = exRd;
  assign hzSmall.mem_branch_taken_i = branch;
  assign hzSmall.dmem_busy_i        = busy;

  pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i   (clk),
    .reset_i (rstN),
    .hz      (hzIf)
  );

  pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(4), .MAX_WAIT(MAX_WAIT)) dutSmall (
    .clk_i   (clk),
    .reset_i (rstN),
    .hz      (hzSmall)
  );

  logic [6:0] actCtrl;
  assign actCtrl = {hzIf.pc_stall_o, hzIf.ifid_stall_o, hzIf.idex_stall_o, hzIf.exmem_stall_o,
                    hzIf.ifid_flush_o, hzIf.idex_flush_o, hzIf.exmem_flush_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] modelCtrl();
    bit hazard;
    if (!rstN) return EXP_IDLE;
    hazard = exMemread && (exRd != 5'd0) && ((exRd == idRs1) || (exRd == idRs2));
    if (busy) return EXP_FREEZE;
    if (branch) return EXP_FLUSH;
    if (hazard && !mBubbleInEx) return EXP_LU;
    return EXP_IDLE;
  endfunction

  function automatic logic [3:0] sat4(input int unsigned v);
    return (v > 15) ? 4'hF : v[3:0];
  endfunction

  task automatic modelReset();
    mBubbleInEx = 0;
    mBusyRun    = 0;
    mTimeout    = 0;
    mStall      = 0;
    mFlush      = 0;
  endtask

  task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic mr,
                       input logic [4:0] rd, input logic br, input logic bz);
    @(negedge clk);
    idRs1 = r1; idRs2 = r2; exMemread = mr; exRd = rd; branch = br; busy = bz;
    #1;
  endtask

  task automatic tick();
    logic [6:0] e;
    e = modelCtrl();
    @(posedge clk);
    if (rstN) begin
      if (e[6]) mStall++;
      if (e[2]) mFlush++;
      mBusyRun = busy ? mBusyRun + 1 : 0;
      if (mBusyRun > MAX_WAIT) mTimeout = 1;
      mBubbleInEx = (e == EXP_LU);
    end
    #1;
  endtask

  task automatic test_reset();
    idRs1 = 5'd5; idRs2 = 5'd0; exMemread = 1'b1; exRd = 5'd5; branch = 1'b1; busy = 1'b1;
    #12;
    checks++;
    if (actCtrl !== EXP_IDLE) $display("[TB] FAIL reset_ctrl: got %b expected %b", actCtrl, EXP_IDLE);
    else passes++;
    checks++;
    if (hzIf.stall_cnt_o !== 32'd0 || hzIf.flush_cnt_o !== 32'd0 || hzIf.timeout_o !== 1'b0)
      $display("[TB] FAIL reset_state: stall %0d flush %0d timeout %b expected 0 0 0",
               hzIf.stall_cnt_o, hzIf.flush_cnt_o, hzIf.timeout_o);
    else passes++;
    @(negedge clk);
    idRs1 = 5'd0; idRs2 = 5'd0; exMemread = 1'b0; exRd = 5'd0; branch = 1'b0; busy = 1'b0;
    rstN = 1'b1;
    modelReset();
    #1;
    checks++;
    if (actCtrl !== EXP_IDLE) $display("[TB] FAIL reset_release: got %b expected %b", actCtrl, EXP_IDLE);
    else passes++;
    tick();
  endtask

  task automatic test_load_use();
    drive(5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0);
    checks++;
    if (actCtrl !== EXP_LU) $display("[TB] FAIL lu_stall: got %b expected %b", actCtrl, EXP_LU);
    else passes++;
    tick();
    drive(5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0);
    checks++;
    if (actCtrl !== EXP_IDLE) $display("[TB] FAIL lu_single_cycle: got %b expected %b", actCtrl, EXP_IDLE);
    else passes++;
    tick();
    checks++;
    if (hzIf.stall_cnt_o !== 32'd1) $display("[TB] FAIL lu_stall_cnt: got %0d expected 1", hzIf.stall_cnt_o);
    else passes++;
    drive(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    checks++;
    if (actCtrl !== EXP_IDLE) $display("[TB] FAIL lu_x0_masked: got %b expected %b", actCtrl, EXP_IDLE);
    else passes++;
    tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      drive(5'd7, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0);
      tick();
      drive(5'd7, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0);
      tick();
      if (i == 9) begin
        checks++;
        if (hzSmall.stall_cnt_o !== 4'd11) $display("[TB] FAIL sat_mid: got %0d expected 11", hzSmall.stall_cnt_o);
        else passes++;
      end
    end
    checks++;
    if (hzSmall.stall_cnt_o !== 4'hF) $display("[TB] FAIL sat_hold: got %h expected f", hzSmall.stall_cnt_o);
    else passes++;
    checks++;
    if (hzIf.stall_cnt_o !== mStall) $display("[TB] FAIL sat_wide_cnt: got %0d expected %0d", hzIf.stall_cnt_o, mStall);
    else passes++;
  endtask

  task automatic test_branch_over_load_use();
    int unsigned flushBefore;
    flushBefore = mFlush;
    drive(5'd0, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0);
    checks++;
    if (actCtrl !== EXP_FLUSH) $display("[TB] FAIL branch_wins: got %b expected %b", actCtrl, EXP_FLUSH);
    else passes++;
    tick();
    checks++;
    if (hzIf.flush_cnt_o !== flushBefore + 1) $display("[TB] FAIL branch_flush_cnt: got %0d expected %0d", hzIf.flush_cnt_o, flushBefore + 1);
    else passes++;
    drive(5'd0, 5'd3, 1'b1, 5'd3, 1'b0, 1'b0);
    checks++;
    if (actCtrl !== EXP_LU) $display("[TB] FAIL branch_stays_run: got %b expected %b", actCtrl, EXP_LU);
    else passes++;
    tick();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_freeze_branch();
    int unsigned stallBefore;
    stallBefore = mStall;
    for (int i = 0; i < 3; i++) begin
      drive(5'd1, 5'd2, 1'b0, 5'd4, 1'b1, 1'b1);
      checks++;
      if (actCtrl !== EXP_FREEZE) $display("[TB] FAIL freeze_cycle%0d: got %b expected %b", i, actCtrl, EXP_FREEZE);
      else passes++;
      tick();
    end
    drive(5'd1, 5'd2, 1'b0, 5'd4, 1'b1, 1'b0);
    checks++;
    if (actCtrl !== EXP_FLUSH) $display("[TB] FAIL freeze_then_flush: got %b expected %b", actCtrl, EXP_FLUSH);
    else passes++;
    tick();
    checks++;
    if (hzIf.stall_cnt_o !== stallBefore + 3) $display("[TB] FAIL freeze_stall_cnt: got %0d expected %0d", hzIf.stall_cnt_o, stallBefore + 3);
    else passes++;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_timeout();
    for (int i = 1; i <= MAX_WAIT + 1; i++) begin
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      tick();
      if (i >= MAX_WAIT) begin
        checks++;
        if (hzIf.timeout_o !== (i > MAX_WAIT)) $display("[TB] FAIL timeout_after_%0d: got %b expected %b", i, hzIf.timeout_o, i > MAX_WAIT);
        else passes++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();
    end
    checks++;
    if (hzIf.timeout_o !== 1'b1) $display("[TB] FAIL timeout_sticky: got %b expected 1", hzIf.timeout_o);
    else passes++;
  endtask

  task automatic test_async_reset();
    // Abort from LU_STALL
    drive(5'd6, 5'd0, 1'b1, 5'd6, 1'b0, 1'b0);
    tick();
    drive(5'd6, 5'd0, 1'b1, 5'd6, 1'b0, 1'b1);
    #2 rstN = 1'b0;
    #1;
    checks++;
    if (actCtrl !== EXP_IDLE || hzIf.stall_cnt_o !== 32'd0 || hzIf.flush_cnt_o !== 32'd0 || hzIf.timeout_o !== 1'b0)
      $display("[TB] FAIL async_rst_lu: ctrl %b stall %0d flush %0d timeout %b expected all 0",
               actCtrl, hzIf.stall_cnt_o, hzIf.flush_cnt_o, hzIf.timeout_o);
    else passes++;
    modelReset();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    rstN = 1'b1;
    tick();
    drive(5'd6, 5'd0, 1'b1, 5'd6, 1'b0, 1'b0);
    checks++;
    if (actCtrl !== EXP_LU) $display("[TB] FAIL async_rst_resume_run: got %b expected %b", actCtrl, EXP_LU);
    else passes++;
    tick();
    // Abort from FREEZE part-way into a long busy run
    for (int i = 0; i < 10; i++) begin
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      tick();
    end
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    #2 rstN = 1'b0;
    #1;
    checks++;
    if (actCtrl !== EXP_IDLE || hzIf.stall_cnt_o !== 32'd0)
      $display("[TB] FAIL async_rst_freeze: ctrl %b stall %0d expected 0 0", actCtrl, hzIf.stall_cnt_o);
    else passes++;
    modelReset();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    rstN = 1'b1;
    tick();
    for (int i = 0; i < MAX_WAIT; i++) begin
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      tick();
    end
    checks++;
    if (hzIf.timeout_o !== 1'b0) $display("[TB] FAIL async_rst_wait_cleared: got %b expected 0", hzIf.timeout_o);
    else passes++;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_random();
    logic [6:0] e;
    logic       bz;
    int         ctrlErrs;
    int         cntErrs;
    ctrlErrs = 0;
    cntErrs  = 0;
    bz       = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bz = bz ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 99) < 15);
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), bz);
      e = modelCtrl();
      checks++;
      if (actCtrl !== e) begin
        if (ctrlErrs < 10) $display("[TB] FAIL rand_ctrl cycle %0d: got %b expected %b", i, actCtrl, e);
        ctrlErrs++;
      end else passes++;
      tick();
      checks++;
      if (hzIf.stall_cnt_o !== mStall || hzIf.flush_cnt_o !== mFlush || hzIf.timeout_o !== mTimeout ||
          hzSmall.stall_cnt_o !== sat4(mStall) || hzSmall.flush_cnt_o !== sat4(mFlush)) begin
        if (cntErrs < 10)
          $display("[TB] FAIL rand_counters cycle %0d: got stall %0d flush %0d timeout %b small %0d/%0d expected %0d %0d %b %0d/%0d",
                   i, hzIf.stall_cnt_o, hzIf.flush_cnt_o, hzIf.timeout_o, hzSmall.stall_cnt_o, hzSmall.flush_cnt_o,
                   mStall, mFlush, mTimeout, sat4(mStall), sat4(mFlush));
        cntErrs++;
      end else passes++;
    end
  endtask

  initial begin
    rstN = 1'b0;
    modelReset();
    test_reset();
    test_load_use();
    test_saturation();
    test_branch_over_load_use();
    test_freeze_branch();
    test_timeout();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
